// File: rtl/udp_encoder.sv
// rtl/udp_encoder.sv - transmit-side UDP framer with payload buffer and checksum
//
// Latches the IP/UDP header fields on start, buffers up to MAX_PAYLOAD_WORDS
// payload words, then streams {src_port,dest_port}, {len_udp,checksum} and
// the payload as 32-bit words with no backpressure.
//
// Optional feature macro: UDP_ENC_CHECKSUM_EN
//   defined   - UDP checksum over pseudo-header, header and payload, with two
//               fold cycles between the last payload word and the header.
//   undefined - checksum field sent as 0x0000, header follows immediately.
//
// Ports:
//   clk, reset (async, active-low)
//   src_ip, dest_ip        pseudo-header addresses (checksum only)
//   src_port, dest_port    UDP ports
//   len_data               payload length in bytes
//   start                  request, honoured only when idle
//   data_in, data_valid    payload words, big-endian
//   busy                   block not idle
//   err                    one-cycle pulse for an oversize request
//   len_udp                latched len_data + 8
//   data_out, out_valid    datagram word stream
//   fin                    marks the last datagram word
module udp_encoder #(
    parameter int MAX_PAYLOAD_WORDS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] src_ip,
    input  logic [31:0] dest_ip,
    input  logic [15:0] src_port,
    input  logic [15:0] dest_port,
    input  logic [15:0] len_data,
    input  logic        start,
    input  logic [31:0] data_in,
    input  logic        data_valid,
    output logic        busy,
    output logic        err,
    output logic [15:0] len_udp,
    output logic [31:0] data_out,
    output logic        out_valid,
    output logic        fin
);

    localparam int AW    = (MAX_PAYLOAD_WORDS > 1) ? $clog2(MAX_PAYLOAD_WORDS) : 1;
    localparam int WW    = $clog2(MAX_PAYLOAD_WORDS + 1);
    localparam int DEPTH = 1 << AW;
    localparam logic [16:0] MAX_BYTES = 17'(4 * MAX_PAYLOAD_WORDS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        HDR0  = 3'd2,
        HDR1  = 3'd3,
        DATA  = 3'd4
`ifdef UDP_ENC_CHECKSUM_EN
        ,
        FOLD1 = 3'd5,
        FOLD2 = 3'd6
`endif
    } state_t;

`ifdef UDP_ENC_CHECKSUM_EN
    localparam state_t POST_LOAD = FOLD1;
`else
    localparam state_t POST_LOAD = HDR0;
`endif

    state_t          state, state_n;
    logic            err_q;
    logic [15:0]     src_port_q, dest_port_q;
    logic [WW-1:0]   words, idx;
    logic [31:0]     mem [DEPTH];

    logic            oversize, idx_last, accept;
    logic [WW-1:0]   words_calc;
    logic [31:0]     last_mask, word_in;
    logic [15:0]     csum_field;

    assign oversize   = {1'b0, len_data} > MAX_BYTES;
    // Only meaningful when not oversize, where the quotient fits in WW bits.
    assign words_calc = WW'(len_data[WW+1:2]) + WW'(|len_data[1:0]);
    assign idx_last   = (idx == words - WW'(1));
    assign accept     = (state == LOAD) && data_valid;

    // len_udp = len_data + 8 keeps the same two low bits as len_data.
    always_comb begin
        last_mask = 32'hffff_ffff;
        case (len_udp[1:0])
            2'd1:    last_mask = 32'hff00_0000;
            2'd2:    last_mask = 32'hffff_0000;
            2'd3:    last_mask = 32'hffff_ff00;
            default: last_mask = 32'hffff_ffff;
        endcase
    end

    assign word_in = idx_last ? (data_in & last_mask) : data_in;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[idx[AW-1:0]] <= word_in;
        end
    end

`ifdef UDP_ENC_CHECKSUM_EN
    logic [31:0] acc, hdr_sum;
    logic [15:0] csum_raw, len_plus8;

    assign len_plus8 = len_data + 16'd8;
    // Pseudo-header plus UDP header; len_udp appears in both.
    assign hdr_sum = 32'(src_ip[31:16]) + 32'(src_ip[15:0]) +
                     32'(dest_ip[31:16]) + 32'(dest_ip[15:0]) +
                     32'h0000_0011 + 32'(len_plus8) +
                     32'(src_port) + 32'(dest_port) + 32'(len_plus8);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= 32'd0;
        end else if (state == IDLE && start) begin
            acc <= hdr_sum;
        end else if (accept) begin
            acc <= acc + 32'(word_in[31:16]) + 32'(word_in[15:0]);
        end else if (state == FOLD1 || state == FOLD2) begin
            acc <= 32'(acc[15:0]) + 32'(acc[31:16]);
        end
    end

    // A computed zero is sent as all-ones; zero means "no checksum".
    assign csum_raw   = ~acc[15:0];
    assign csum_field = (csum_raw == 16'h0000) ? 16'hffff : csum_raw;
`else
    logic unused_ip;
    assign unused_ip  = ^{src_ip, dest_ip};
    assign csum_field = 16'h0000;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            err_q       <= 1'b0;
            len_udp     <= 16'd0;
            src_port_q  <= 16'd0;
            dest_port_q <= 16'd0;
            words       <= '0;
            idx         <= '0;
        end else begin
            state <= state_n;
            err_q <= 1'b0;
            if (state == IDLE && start) begin
                src_port_q  <= src_port;
                dest_port_q <= dest_port;
                len_udp     <= len_data + 16'd8;
                words       <= words_calc;
                err_q       <= oversize;
                idx         <= '0;
            end
            if (accept || state == DATA) begin
                idx <= idx_last ? '0 : idx + WW'(1);
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (start && !oversize) state_n = (len_data == 16'd0) ? POST_LOAD : LOAD;
            LOAD: if (data_valid && idx_last) state_n = POST_LOAD;
`ifdef UDP_ENC_CHECKSUM_EN
            FOLD1: state_n = FOLD2;
            FOLD2: state_n = HDR0;
`endif
            HDR0: state_n = HDR1;
            HDR1: state_n = (words == '0) ? IDLE : DATA;
            DATA: if (idx_last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        data_out  = 32'd0;
        out_valid = 1'b0;
        fin       = 1'b0;
        case (state)
            HDR0: begin
                data_out  = {src_port_q, dest_port_q};
                out_valid = 1'b1;
            end
            HDR1: begin
                data_out  = {len_udp, csum_field};
                out_valid = 1'b1;
                fin       = (words == '0);
            end
            DATA: begin
                data_out  = mem[idx[AW-1:0]];
                out_valid = 1'b1;
                fin       = idx_last;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);
    assign err  = err_q;

endmodule

// File: tb/tb_udp_encoder.sv
// tb/tb_udp_encoder.sv - self-checking bench for udp_encoder
module tb_udp_encoder;

    localparam int MAXW = 16;
`ifdef UDP_ENC_CHECKSUM_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] src_ip, dest_ip, data_in;
    logic [15:0] src_port, dest_port, len_data;
    logic        start, data_valid;
    logic        busy, err, out_valid, fin;
    logic [15:0] len_udp;
    logic [31:0] data_out;

    int checks = 0;
    int errors = 0;
    logic [31:0] pay[$];

    always #5 clk = ~clk;

    udp_encoder #(.MAX_PAYLOAD_WORDS(MAXW)) dut (
        .clk(clk), .reset(reset),
        .src_ip(src_ip), .dest_ip(dest_ip),
        .src_port(src_port), .dest_port(dest_port),
        .len_data(len_data), .start(start),
        .data_in(data_in), .data_valid(data_valid),
        .busy(busy), .err(err), .len_udp(len_udp),
        .data_out(data_out), .out_valid(out_valid), .fin(fin)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pbyte(input int b);
        logic [31:0] w;
        w = pay[b / 4];
        return w[31 - 8 * (b % 4) -: 8];
    endfunction

    // Internet checksum computed byte-wise from the datagram contents.
    function automatic logic [15:0] model_csum(input logic [31:0] sip, input logic [31:0] dip,
                                               input logic [15:0] sp, input logic [15:0] dp,
                                               input int len);
`ifdef UDP_ENC_CHECKSUM_EN
        logic [31:0] s;
        logic [15:0] c;
        int ulen;
        ulen = len + 8;
        s = sip[31:16] + sip[15:0] + dip[31:16] + dip[15:0] + 32'h11 + ulen[15:0]
            + sp + dp + ulen[15:0];
        for (int b = 0; b < len; b += 2)
            s += {16'h0, pbyte(b), (b + 1 < len) ? pbyte(b + 1) : 8'h00};
        while ((s >> 16) != 0) s = (s & 32'hffff) + (s >> 16);
        c = ~s[15:0];
        return (c == 16'h0) ? 16'hffff : c;
`else
        return 16'h0000 ^ {sip[0], 15'h0} ^ {sip[0], 15'h0} ^ dip[31:16] ^ dip[31:16]
               ^ sp ^ sp ^ dp ^ dp ^ 16'(len) ^ 16'(len);
`endif
    endfunction

    task automatic send(input logic [31:0] sip, input logic [31:0] dip,
                        input logic [15:0] sp, input logic [15:0] dp, input int len,
                        input bit gaps, input bit restart);
        int nw, first, gapc, b;
        bit done;
        logic [31:0] exp[$];
        logic [31:0] got[$];
        logic [31:0] w;
        nw = (len + 3) / 4;
        src_ip = sip; dest_ip = dip; src_port = sp; dest_port = dp; len_data = 16'(len);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("len_udp", {16'd0, len_udp}, 32'(len + 8));
        for (int i = 0; i < nw; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    data_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            if (restart && i == 1) begin
                data_valid = 1'b0;
                start = 1'b1; src_port = ~sp; dest_port = ~dp; len_data = 16'd5;
                @(posedge clk); #1;
                start = 1'b0;
            end
            data_valid = 1'b1;
            data_in = pay[i];
            @(posedge clk); #1;
        end
        data_valid = 1'b0;
        data_in = $urandom;

        exp.push_back({sp, dp});
        exp.push_back({16'(len + 8), model_csum(sip, dip, sp, dp, len)});
        for (int i = 0; i < nw; i++) begin
            for (int k = 0; k < 4; k++) begin
                b = 4 * i + k;
                w[31 - 8 * k -: 8] = (b < len) ? pbyte(b) : 8'h00;
            end
            exp.push_back(w);
        end

        first = -1; gapc = 0; done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            if (out_valid) begin
                if (first < 0) first = c;
                got.push_back(data_out);
                if (fin) done = 1'b1;
            end else if (first >= 0) begin
                gapc++;
            end
            if (!done) begin
                @(posedge clk); #1;
            end
        end
        check("fin_seen", {31'd0, done}, 32'd1);
        check("hdr0_latency", first, LAT);
        check("word_count", got.size(), exp.size());
        check("valid_gaps", gapc, 0);
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("word%0d_len%0d", i, len), got[i], exp[i]);
        @(posedge clk); #1;
        check("busy_after_fin", {31'd0, busy}, 32'd0);
        check("valid_after_fin", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcount, len;
        reset = 1'b0; start = 1'b0; data_valid = 1'b0; data_in = '0;
        src_ip = '0; dest_ip = '0; src_port = '0; dest_port = '0; len_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_fin", {31'd0, fin}, 32'd0);
        check("rst_data_out", data_out, 32'd0);
        check("rst_len_udp", {16'd0, len_udp}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Nominal "Hello World"; the low byte of the last word must be dropped.
        pay = '{32'h48656c6c, 32'h6f20576f, 32'h726c64a5};
        send(32'h9801331b, 32'h980e5e4b, 16'ha08f, 16'h2694, 11, 1'b0, 1'b0);

        // Zero-length payload.
        send(32'h9801331b, 32'h980e5e4b, 16'ha08f, 16'h2694, 0, 1'b0, 1'b0);

        // Oversize request.
        src_ip = 32'h01020304; len_data = 16'd65; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("oversize_err", {31'd0, err}, 32'd1);
        check("oversize_busy", {31'd0, busy}, 32'd0);
        vcount = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (c == 0) check("oversize_err_drop", {31'd0, err}, 32'd0);
            if (out_valid || busy) vcount++;
        end
        check("oversize_no_output", vcount, 0);

        // Ignored start during LOAD plus data_valid gaps.
        pay = '{32'h48656c6c, 32'h6f20576f, 32'h726c64a5};
        send(32'h9801331b, 32'h980e5e4b, 16'ha08f, 16'h2694, 11, 1'b1, 1'b1);

        // Reset during LOAD after one accepted word.
        src_ip = 32'h9801331b; dest_ip = 32'h980e5e4b; src_port = 16'ha08f;
        dest_port = 16'h2694; len_data = 16'd11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; data_valid = 1'b1; data_in = 32'h48656c6c;
        @(posedge clk); #1;
        data_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_fin", {31'd0, fin}, 32'd0);
        check("midrst_data_out", data_out, 32'd0);
        check("midrst_len_udp", {16'd0, len_udp}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        pay = '{32'h48656c6c, 32'h6f20576f, 32'h726c64a5};
        send(32'h9801331b, 32'h980e5e4b, 16'ha08f, 16'h2694, 11, 1'b0, 1'b0);

        // Boundary: maximum payload, then randomized datagrams.
        pay.delete();
        for (int i = 0; i < MAXW; i++) pay.push_back($urandom);
        send($urandom, $urandom, 16'($urandom), 16'($urandom), 4 * MAXW, 1'b0, 1'b0);
        for (int t = 0; t < 10; t++) begin
            len = (t == 0) ? 1 : (t == 1) ? 4 : $urandom_range(1, 4 * MAXW);
            pay.delete();
            for (int i = 0; i < (len + 3) / 4; i++) pay.push_back($urandom);
            send($urandom, $urandom, 16'($urandom), 16'($urandom), len,
                 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/udp_encoder.md
# udp_encoder

Transmit-side UDP framer and the counterpart of the UDP decoder. Latches the IP/UDP header fields on `start` and buffers the payload words while accumulating the UDP checksum over the pseudo-header, header and payload. It then emits the complete datagram as a stream of 32-bit words: two header words followed by the payload. The output feeds the IP-layer transmit path.

## Interface
- `MAX_PAYLOAD_WORDS`, 16: depth of the internal payload buffer in 32-bit words. Maximum payload is 4*MAX_PAYLOAD_WORDS bytes.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `src_ip`, `dest_ip`  in  32  IPv4 addresses; used only for the pseudo-header sum.
- `src_port`, `dest_port`  in  16  UDP ports.
- `len_data`  in  16  payload length in bytes.
- `start`  in  1  one-cycle request; samples all field inputs.
- `data_in`  in  32  payload word, big-endian (first byte in [31:24]).
- `data_valid`  in  1  `data_in` qualifier.
- `busy`  out  1  high whenever the block is not IDLE.
- `err`  out  1  one-cycle pulse for an oversize request.
- `len_udp`  out  16  latched `len_data`+8.
- `data_out`  out  32  datagram word.
- `out_valid`  out  1  `data_out` qualifier.
- `fin`  out  1  pulses with the last datagram word.

## Operation
- States: IDLE, LOAD, FOLD1, FOLD2, HDR0, HDR1, DATA.
- **IDLE**
  - `start` is honoured only in IDLE; it is ignored otherwise. `data_valid` is ignored outside LOAD.
  - On `start`, latch the ports, the IPs and `len_data`; compute `len_udp` = `len_data`+8 and `words` = ceil(`len_data`/4).
  - Load the 32-bit checksum accumulator with the sum of 16-bit fields: src_ip hi/lo, dest_ip hi/lo, 0x0011, len_udp (pseudo-header), src_port, dest_port, len_udp (header). The checksum field counts as 0.
  - If `len_data` > 4*MAX_PAYLOAD_WORDS: pulse `err`, remain IDLE, `busy` stays 0.
  - If `len_data` = 0: go to FOLD1.
  - Otherwise: go to LOAD.
- **LOAD**
  - Each cycle with `data_valid`=1, store the word at the write index and add its upper and lower halves to the accumulator.
  - On the last word, bytes beyond `len_data` are forced to 0 both in the buffer and in the sum.
  - After `words` accepts, go to FOLD1.
- **FOLD1 / FOLD2**
  - In each state: acc = acc[15:0] + acc[31:16].
  - At the end of FOLD2: checksum = ~acc[15:0]. A result of 0x0000 is transmitted as 0xFFFF.
- **HDR0**: `data_out`={src_port,dest_port}.
- **HDR1**: `data_out`={len_udp,checksum}.
  - If `len_data`=0, assert `fin` here and return to IDLE.
- **DATA**: output the buffered words one per cycle. `fin` is asserted with the final word, then return to IDLE.
- No output backpressure: the datagram streams contiguously, with `out_valid` high for 2+`words` consecutive cycles.
- Accumulator is 32 bits wide and never overflows for any permitted MAX_PAYLOAD_WORDS up to 16383.

## Timing
- Reset values:
  - state IDLE;
  - `busy`, `err`, `out_valid`, `fin` = 0;
  - `data_out`, `len_udp` = 0;
  - accumulator and counters = 0.
  - Buffer contents are don't-care.
- Reset asserted mid-operation aborts immediately to IDLE with the above values; no partial `fin`.
- `start` sampled at edge E: `busy`=1 and `len_udp` valid from the cycle after E; the first payload word is accepted at edge E+1 at the earliest.
- With the last payload word accepted at edge L, the cycles after L are:
  - first: FOLD1;
  - second: FOLD2;
  - third: HDR0, `out_valid`=1;
  - fourth: HDR1;
  - following cycles: payload words.
- `busy` drops in the cycle after the `fin` cycle; a new `start` is accepted in that cycle.
- `err` is high for exactly the cycle after the offending `start` edge.

## Configuration
- `UDP_ENC_CHECKSUM_EN` defined: the checksum is computed as above, with the FOLD1/FOLD2 latency.
- `UDP_ENC_CHECKSUM_EN` undefined:
  - The accumulator and FOLD states are compiled out.
  - The checksum field is sent as 0x0000 (IPv4 "no checksum").
  - HDR0 follows LOAD, or IDLE for a zero-length payload, in the next cycle.

## Test plan
- **Nominal datagram.** src_ip 0x9801331b, dest_ip 0x980e5e4b, ports 0xa08f→0x2694, `len_data`=11, payload "Hello World" in words 0x48656c6c, 0x6f20576f, 0x726c64XX (don't-care low byte).
  - Output: a08f2694, 00132560, 48656c6c, 6f20576f, 726c6400, with `fin` on the last word and `len_udp`=0x0013.
- **Zero-length payload.** Same fields, `len_data`=0.
  - Output: a08f2694 then {0x0008, checksum}, with `fin` on the second word; there is no LOAD phase.
- **Oversize request.** `len_data`=65 with MAX_PAYLOAD_WORDS=16.
  - `err` high one cycle, `busy` stays 0, no `out_valid`.
- **Ignored inputs.** `start` pulsed again during LOAD, and `data_valid` gaps between words.
  - Latched fields unchanged; the datagram is identical to the nominal case.
- **Reset during LOAD.** Assert `reset` low during LOAD after 1 word.
  - All outputs 0 and `busy`=0 immediately; the next nominal request produces the correct datagram.
- **Checksum disabled.** Build without `UDP_ENC_CHECKSUM_EN` and run the nominal case.
  - Second word is 00130000; HDR0 appears the cycle after the last payload accept.
